// File: rtl/logcap_cmd_issuer.sv
// logcap_cmd_issuer: hub-side initiator for the logic-capture peripheral.
// Takes one host request, loads the peripheral input registers, pulses the
// command, waits for ack, captures the output registers, clears the ack with
// CMD_ACK and returns the result on a valid/ready response channel.
module logcap_cmd_issuer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,  // must be >= 4
   parameter int unsigned ACK_BIT        = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_cmd,
   input  logic [63:0] req_arg,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_timeout,
   output logic [7:0]  rsp_status,
   output logic [63:0] periph_reg_in,
   output logic [7:0]  periph_command,
   output logic        periph_command_strobe,
   input  logic [63:0] periph_reg_out,
   input  logic [7:0]  periph_status,
   output logic        busy,
   output logic [15:0] timeout_count
);

   localparam int unsigned   CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    CMD_NOP = 8'h00;
   localparam logic [7:0]    CMD_ACK = 8'h08;

   typedef enum logic [2:0] {
      IDLE, PRECLR, WAIT_PRECLR, ISSUE, WAIT_ACK, CLR, WAIT_CLR, RESP
   } state_t;

   state_t         r_state;
   logic [7:0]     r_cmd;
   logic [63:0]    r_reg_in;
   logic [7:0]     r_cmd_out;
   logic           r_strobe;
   logic [CW-1:0]  r_cnt;
   logic           r_rsp_valid;
   logic [63:0]    r_rsp_data;
   logic           r_rsp_timeout;
   logic [7:0]     r_rsp_status;
   logic [15:0]    r_to_count;
   logic           w_ack;
   logic           w_cnt_end;

   assign w_ack     = periph_status[ACK_BIT];
   assign w_cnt_end = (r_cnt == CNT_END);

   // Transaction sequencer; strobe/command are registered on entry to the
   // strobing states (PRECLR, ISSUE, CLR) so they are high for exactly that
   // state's single cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_cmd         <= '0;
         r_reg_in      <= '0;
         r_cmd_out     <= '0;
         r_strobe      <= 1'b0;
         r_cnt         <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_timeout <= 1'b0;
         r_rsp_status  <= '0;
         r_to_count    <= '0;
      end else begin
         r_strobe  <= 1'b0;
         r_cmd_out <= '0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_cmd         <= req_cmd;
                  r_reg_in      <= req_arg;
                  r_rsp_data    <= '0;
                  r_rsp_status  <= '0;
                  r_rsp_timeout <= 1'b0;
                  r_strobe      <= 1'b1;
                  if (w_ack) begin
                     r_state   <= PRECLR;
                     r_cmd_out <= CMD_ACK;
                  end else begin
                     r_state   <= ISSUE;
                     r_cmd_out <= req_cmd;
                  end
               end
            end
            PRECLR: begin
               r_state <= WAIT_PRECLR;
               r_cnt   <= '0;
            end
            WAIT_PRECLR: begin
               if (!w_ack) begin
                  r_state   <= ISSUE;
                  r_strobe  <= 1'b1;
                  r_cmd_out <= r_cmd;
               end else if (w_cnt_end) begin
                  r_state       <= RESP;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  if (r_to_count != '1) r_to_count <= r_to_count + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ISSUE: begin
               r_cnt <= '0;
               if (r_cmd == CMD_NOP) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
               end else if (r_cmd == CMD_ACK) begin
                  r_state <= WAIT_CLR;
               end else begin
                  r_state <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (w_ack) begin
                  r_rsp_data   <= periph_reg_out;
                  r_rsp_status <= periph_status;
                  r_state      <= CLR;
                  r_strobe     <= 1'b1;
                  r_cmd_out    <= CMD_ACK;
               end else if (w_cnt_end) begin
                  r_state       <= RESP;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  if (r_to_count != '1) r_to_count <= r_to_count + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            CLR: begin
               r_state <= WAIT_CLR;
               r_cnt   <= '0;
            end
            WAIT_CLR: begin
               if (!w_ack) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
               end else if (w_cnt_end) begin
                  r_state       <= RESP;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  if (r_to_count != '1) r_to_count <= r_to_count + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready             = (r_state == IDLE);
   assign busy                  = (r_state != IDLE);
   assign rsp_valid             = r_rsp_valid;
   assign rsp_data              = r_rsp_data;
   assign rsp_timeout           = r_rsp_timeout;
   assign rsp_status            = r_rsp_status;
   assign periph_reg_in         = r_reg_in;
   assign periph_command        = r_cmd_out;
   assign periph_command_strobe = r_strobe;
   assign timeout_count         = r_to_count;

endmodule

// File: doc/logcap_cmd_issuer.md
Name: logcap_cmd_issuer

Overview:
- Hub-side initiator for the logic-capture peripheral's register/command interface.
- Accepts one host request (command code plus 64-bit argument), presents the argument on the peripheral's eight input registers and pulses the command.
- Waits for the peripheral's acknowledge status bit, captures the eight output registers, then clears the acknowledge with CMD_ACK.
- Returns the result to the host over a valid/ready response channel; sits between the host packet parser and the capture peripheral.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles waited for ack set or ack clear before aborting the transaction; must be at least 4.
- ACK_BIT, 3: index of the acknowledge bit in the peripheral status byte.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  block can accept a request
- req_cmd  in  8  command code
- req_arg  in  64  argument; byte k goes to peripheral input register k
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  64  captured peripheral output registers; byte k comes from output register k
- rsp_timeout  out  1  transaction timed out
- rsp_status  out  8  status byte sampled when ack was seen
- periph_reg_in  out  64  to peripheral input registers 0..7
- periph_command  out  8  command code to peripheral
- periph_command_strobe  out  1  one-cycle command strobe
- periph_reg_out  in  64  from peripheral output registers 0..7
- periph_status  in  8  peripheral status byte: bit0 idle, bit1 preTrigger, bit2 postTrigger, bit3 ack
- busy  out  1  high in any state other than IDLE
- timeout_count  out  16  saturating count of timed-out transactions

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_timeout=0; rsp_status=0; periph_reg_in=0; periph_command=8'h00; periph_command_strobe=0; busy=0; timeout_count=0.
- Request accept: a request is accepted on the cycle where req_valid && req_ready. req_ready is high only in IDLE.
- Capture at accept: req_cmd and req_arg are latched. periph_reg_in is driven from the latched argument on the next cycle and held stable until the block returns to IDLE.
- Command outputs: periph_command is 8'h00 whenever periph_command_strobe is low. The strobe is high for exactly one cycle per issued command. Two strobes are always separated by at least one idle cycle.
- PRECLR: entered from accept if periph_status[ACK_BIT]=1, to clear a stale ack. Issue CMD_ACK (8'h08) for one cycle, then go to WAIT_PRECLR.
- WAIT_PRECLR: wait for ack=0, then go to ISSUE.
- Accept with no stale ack: go directly to ISSUE.
- ISSUE: strobe the latched command for one cycle. Peripheral timing: it registers the command on the following edge and sets ack one edge later, so ack is first visible 2 cycles after the strobe.
- After ISSUE, by command:
  - Command 8'h00 (NOP): no ack is produced; go directly to RESP with rsp_data=0 and rsp_timeout=0.
  - Command 8'h08 (ACK): go to WAIT_CLR.
  - All other commands: go to WAIT_ACK.
- WAIT_ACK: on the first cycle with ack=1, register rsp_data<=periph_reg_out and rsp_status<=periph_status, then go to CLR.
- CLR: strobe 8'h08 for one cycle, then go to WAIT_CLR.
- WAIT_CLR: when ack=0, go to RESP.
- RESP: rsp_valid=1, holding rsp_data/rsp_timeout/rsp_status stable until rsp_ready. On handshake, drop rsp_valid and return to IDLE; the next request may be accepted the following cycle.
- Timeout counter: reloaded to 0 on entry to each WAIT_* state and incremented each cycle spent there.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1 with no exit condition, go to RESP with rsp_timeout=1.
  - rsp_data: 0 if the ack was never seen, otherwise keeps the captured value.
  - timeout_count increments, saturating at 16'hFFFF.
- Exit vs timeout: if the exit condition and the timeout occur in the same cycle, the exit condition wins.
- Reset mid-transaction: immediate return to reset values; any pending response is discarded; no CMD_ACK is issued.
- rsp_ready while rsp_valid=0: ignored.
- req_valid outside IDLE: ignored; the request is not consumed.

Test Plan:
- Buffer config: req_cmd=8'h04, req_arg=64'h0000_0010_0000_0100, peripheral model acks at strobe+2 with reg_out=0 -> periph_reg_in=64'h0000_0010_0000_0100 held stable; exactly two strobes (04 then 08); rsp_valid with rsp_timeout=0 within 8 cycles of accept.
- Read trace size: cmd 8'h06, model reg_out=64'h0000_0000_0000_0400 -> rsp_data=64'h400; rsp_status bit3=1; ack clear observed before rsp_valid.
- Stale ack: periph_status=8'h08 at accept of cmd 8'h01 -> strobe sequence 08, 01, 08; response correct.
- NOP: cmd 8'h00 -> single strobe, rsp_valid 2 cycles after accept, rsp_data=0, no CMD_ACK issued.
- Timeout: TIMEOUT_CYCLES=16, model never acks cmd 8'h07 -> rsp_timeout=1, rsp_data=0, timeout_count=1; a following normal request completes correctly.
- Backpressure/reset: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, req_ready=0; assert reset during WAIT_ACK -> all outputs at reset values next cycle.
